ir_rx_decoder: RTL and testbench



---
 rtl/ir_pkg.sv | 23 ++
 rtl/ir_rx_sync.sv | 24 ++
 rtl/ir_rx_decoder.sv | 149 ++++++++++++++
 tb/tb_ir_rx_decoder.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ir_pkg.sv
// Shared IR link definitions: frame format, FSM states and a voting helper.
// Used by both the receive and transmit sides.
package ir_pkg;

    localparam int DATA_BITS        = 8;
    localparam int DEFAULT_BIT_CLKS = 50000;

    localparam logic MARK  = 1'b1;
    localparam logic SPACE = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_SPACE
    } ir_state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/ir_rx_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// RESET_VAL lets the caller preset both flops to the line's idle level.
module ir_rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [1:0] sync_ff;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_ff <= {2{RESET_VAL}};
        end else begin
            sync_ff <= {sync_ff[0], d};
        end
    end

    assign q = sync_ff[1];

endmodule

// File: rtl/ir_rx_decoder.sv
// IR receive decoder: mid-bit sampling of start/8 data/stop frames from the demodulated pin.
// Optional IRRX_MAJORITY_EN: each sample is a 3-cycle majority vote, decided one cycle later.
module ir_rx_decoder
    import ir_pkg::*;
#(
    parameter int BIT_CLKS = DEFAULT_BIT_CLKS
) (
    input  logic                 CLK_50M,
    input  logic                 reset_n,
    input  logic                 rxd_n,
    output logic [DATA_BITS-1:0] Dout,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CNT_W = $clog2(BIT_CLKS);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CLKS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    // Only the start sample moves later with voting; later windows keep the same spacing.
`ifdef IRRX_MAJORITY_EN
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(BIT_CLKS / 2);
`else
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(BIT_CLKS / 2 - 1);
`endif

    ir_state_t            state;
    ir_state_t            state_next;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 rxd_sync;
    logic                 rx_bit;
    logic                 sample_bit;
    logic                 cnt_clr;
    logic                 shift_en;
    logic                 byte_done;
    logic                 stop_err;

    ir_rx_sync #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clock  (CLK_50M),
        .reset_n(reset_n),
        .d      (rxd_n),
        .q      (rxd_sync)
    );

    assign rx_bit = ~rxd_sync;

`ifdef IRRX_MAJORITY_EN
    logic [1:0] rx_hist;

    always_ff @(posedge CLK_50M or negedge reset_n) begin
        if (!reset_n) begin
            rx_hist <= {2{SPACE}};
        end else begin
            rx_hist <= {rx_hist[0], rx_bit};
        end
    end

    assign sample_bit = majority3(rx_bit, rx_hist[0], rx_hist[1]);
`else
    assign sample_bit = rx_bit;
`endif

    always_ff @(posedge CLK_50M or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // WAIT_SPACE holds off a new start until a stuck mark has been released.
    always_comb begin
        state_next = state;
        cnt_clr    = 1'b0;
        shift_en   = 1'b0;
        byte_done  = 1'b0;
        stop_err   = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_clr = 1'b1;
                if (rx_bit == MARK) state_next = START;
            end
            START: begin
                if (cnt == START_LAST) begin
                    cnt_clr    = 1'b1;
                    state_next = (sample_bit == MARK) ? DATA : IDLE;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_clr  = 1'b1;
                    shift_en = 1'b1;
                    if (bit_idx == IDX_LAST) state_next = STOP;
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_clr = 1'b1;
                    if (sample_bit == SPACE) begin
                        byte_done  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        stop_err   = 1'b1;
                        state_next = WAIT_SPACE;
                    end
                end
            end
            WAIT_SPACE: begin
                cnt_clr = 1'b1;
                if (rx_bit == SPACE) state_next = IDLE;
            end
            default: begin
                cnt_clr    = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_50M or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            Dout      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            cnt       <= cnt_clr ? '0 : cnt + 1'b1;
            valid     <= byte_done;
            frame_err <= stop_err;
            if (state != DATA) begin
                bit_idx <= '0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + 1'b1;
            end
            if (shift_en) shift_reg <= {sample_bit, shift_reg[DATA_BITS-1:1]};
            if (byte_done) Dout <= shift_reg;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_ir_rx_decoder.sv
// Testbench for ir_rx_decoder at BIT_CLKS=16: directed frames plus random bytes/gaps,
// checked against a frame-level timing and content model.
module tb_ir_rx_decoder;

    localparam int B = 16;
    localparam int H = B / 2;
`ifdef IRRX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif
    // Cycles from the first mark on the pin to the valid/frame_err pulse.
    localparam int LAT = 9 * B + H + 3 + MAJ;

    typedef struct {
        int         at;
        bit         is_err;
        bit         both;
        logic [7:0] data;
    } event_t;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       rxd_n   = 1'b1;
    logic [7:0] dout;
    logic       valid;
    logic       frame_err;
    logic       busy;
    logic       busy_d  = 1'b0;

    int         cyc       = 0;
    int         tests     = 0;
    int         fails     = 0;
    int         origin    = 0;
    int         busy_rise = -1;
    int         busy_fall = -1;
    logic [7:0] model_last = 8'h00;

    event_t obs_q[$];
    event_t exp_q[$];
    bit     wave[$];

    ir_rx_decoder #(
        .BIT_CLKS(B)
    ) dut (
        .CLK_50M  (clk),
        .reset_n  (reset_n),
        .rxd_n    (rxd_n),
        .Dout     (dout),
        .valid    (valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid || frame_err) begin
            obs_q.push_back('{at: cyc, is_err: frame_err, both: valid && frame_err, data: dout});
        end
        if (busy && !busy_d) busy_rise = cyc;
        if (!busy && busy_d) busy_fall = cyc;
        busy_d = busy;
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic queue_idle(input int n);
        repeat (n) wave.push_back(1'b1);
    endtask

    // Pin is active-low: mark (logical 1) drives rxd_n low.
    task automatic queue_frame(input logic [7:0] d, input int stuck_bits, input bit spike,
                               input bit track);
        int         k0;
        logic       lvl;
        logic [7:0] decoded;
        k0 = wave.size();
        repeat (B) wave.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            lvl = ~d[i];
            if (spike) begin
                repeat (H) wave.push_back(lvl);
                wave.push_back(~lvl);
                repeat (B - H - 1) wave.push_back(lvl);
            end else begin
                repeat (B) wave.push_back(lvl);
            end
        end
        repeat (B * stuck_bits) wave.push_back(1'b0);
        repeat (B) wave.push_back(1'b1);
        if (track) begin
            if (stuck_bits > 0) begin
                exp_q.push_back('{at: k0 + LAT, is_err: 1'b1, both: 1'b0, data: model_last});
            end else begin
                decoded = (spike && MAJ == 0) ? ~d : d;
                exp_q.push_back('{at: k0 + LAT, is_err: 1'b0, both: 1'b0, data: decoded});
                model_last = decoded;
            end
        end
    endtask

    task automatic apply_stimulus(input int n);
        origin = cyc;
        for (int k = 0; k < n; k++) begin
            rxd_n = wave[k];
            @(posedge clk);
            #1;
        end
        rxd_n = 1'b1;
    endtask

    task automatic check_events(input string tag);
        int n;
        check_output($sformatf("%s count", tag), obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check_output($sformatf("%s[%0d] cycle", tag, i), obs_q[i].at, origin + exp_q[i].at);
            check_output($sformatf("%s[%0d] kind", tag, i), obs_q[i].is_err, exp_q[i].is_err);
            check_output($sformatf("%s[%0d] Dout", tag, i), obs_q[i].data, exp_q[i].data);
            check_output($sformatf("%s[%0d] excl", tag, i), obs_q[i].both, 1'b0);
        end
        obs_q.delete();
        exp_q.delete();
        wave.delete();
    endtask

    initial begin
        logic [7:0] d;

        reset_n = 1'b0;
        rxd_n   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_output("reset Dout", dout, 8'h00);
        check_output("reset valid", valid, 1'b0);
        check_output("reset frame_err", frame_err, 1'b0);
        check_output("reset busy", busy, 1'b0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Single frame: timing of the strobe and busy window.
        queue_frame(8'hA5, 0, 1'b0, 1'b1);
        queue_idle(2 * B);
        apply_stimulus(wave.size());
        check_output("a5 busy rise", busy_rise, origin + 3);
        check_output("a5 busy fall", busy_fall, origin + LAT);
        check_events("a5");

        queue_frame(8'h00, 0, 1'b0, 1'b1);
        queue_frame(8'hFF, 0, 1'b0, 1'b1);
        queue_idle(2 * B);
        apply_stimulus(wave.size());
        check_events("b2b");

        // Short mark glitch: START is entered then abandoned at its sample point.
        queue_idle(B);
        repeat (4) wave.push_back(1'b0);
        queue_idle(3 * B);
        apply_stimulus(wave.size());
        check_output("glitch busy rise", busy_rise, origin + B + 3);
        check_output("glitch busy fall", busy_fall, origin + B + 3 + H + MAJ);
        check_output("glitch busy end", busy, 1'b0);
        check_events("glitch");

        queue_frame(8'h3C, 3, 1'b0, 1'b1);
        queue_frame(8'h11, 0, 1'b0, 1'b1);
        queue_idle(2 * B);
        apply_stimulus(wave.size());
        check_events("stuck");

        // Reset in the middle of data bit 4 discards the partial byte.
        queue_frame(8'h77, 0, 1'b0, 1'b0);
        apply_stimulus(5 * B + H);
        reset_n = 1'b0;
        #1;
        check_output("midrst Dout", dout, 8'h00);
        check_output("midrst valid", valid, 1'b0);
        check_output("midrst frame_err", frame_err, 1'b0);
        check_output("midrst busy", busy, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset_n    = 1'b1;
        model_last = 8'h00;
        check_events("midrst");
        queue_idle(B);
        queue_frame(8'h5A, 0, 1'b0, 1'b1);
        queue_idle(2 * B);
        apply_stimulus(wave.size());
        check_events("after_rst");

        queue_frame(8'hC3, 0, 1'b1, 1'b1);
        queue_idle(2 * B);
        apply_stimulus(wave.size());
        check_events("spike");

        for (int r = 0; r < 6; r++) begin
            d = 8'($urandom);
            queue_idle($urandom_range(0, B));
            queue_frame(d, 0, 1'b0, 1'b1);
        end
        queue_idle(2 * B);
        apply_stimulus(wave.size());
        check_events("random");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
